// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle, 32 steps per operation.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic        div_q, div_d;
  logic        rs_neg_q, rs_neg_d;
  logic        rt_neg_q, rt_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_acc, prod_fix;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem, div_quo, quo_fix, rem_fix;

  always_comb begin
    rs_neg = op[0] & rs_data[31];
    rt_neg = op[0] & rt_data[31];
    rs_mag = rs_neg ? (32'd0 - rs_data) : rs_data;
    rt_mag = rt_neg ? (32'd0 - rt_data) : rt_data;

    // Multiply: add into the upper half, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    mul_acc  = {mul_sum, acc_q[31:1]};
    prod_fix = (rs_neg_q ^ rt_neg_q) ? (64'd0 - mul_acc) : mul_acc;

    // Divide: partial remainder lives in acc[31:0], quotient shifts into a_q.
    div_shift = {acc_q[31:0], a_q[31]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? (div_shift[31:0] - b_q) : div_shift[31:0];
    div_quo   = {a_q[30:0], div_ge};
    // With a zero divisor the remainder ends up as |rs|, so the usual sign fix restores rs.
    quo_fix   = dz_q ? 32'hFFFF_FFFF
                     : ((rs_neg_q ^ rt_neg_q) ? (32'd0 - div_quo) : div_quo);
    rem_fix   = rs_neg_q ? (32'd0 - div_rem) : div_rem;
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    rs_neg_d = rs_neg_q;
    rt_neg_d = rt_neg_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      StIdle, StFin: begin
        if (state_q == StIdle && start) begin
          div_d    = op[1];
          rs_neg_d = rs_neg;
          rt_neg_d = rt_neg;
          dz_d     = op[1] & (rt_data == 32'd0);
          a_d      = rs_mag;
          b_d      = rt_mag;
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
          state_d  = StCalc;
        end else begin
          if (hi_wr) hi_d = wr_data;
          if (lo_wr) lo_d = wr_data;
          if (state_q == StFin) state_d = StIdle;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 6'd1;
        if (div_q) begin
          acc_d = {32'd0, div_rem};
          a_d   = div_quo;
        end else begin
          acc_d = mul_acc;
          b_d   = {1'b0, b_q[31:1]};
        end
        if (cnt_q == 6'd31) begin
          state_d = StFin;
          done_d  = 1'b1;
          dbz_d   = dz_q;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, latency, reset abort and
// HI/LO write interference, all against hand-computed values.
module tb_muldiv_unit;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpDiv   = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int n;
  int seen;

  muldiv_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hi_wr       (hi_wr),
    .lo_wr       (lo_wr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One idle cycle first so a preceding FIN cycle never swallows the start.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    tick();
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  // n counts cycles since start was asserted; -1 if done never arrives.
  task automatic wait_done(input int k0, output int cnt);
    cnt = k0;
    while (cnt < 45 && done !== 1'b1) begin
      tick();
      cnt++;
    end
    if (done !== 1'b1) cnt = -1;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b);
    int lat;
    issue(o, a, b);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    chk({tag, "_latency"}, lat, 32'd33);
  endtask

  initial begin
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    #21 reset = 1'b1;

    // Preload HI/LO so that the reset abort visibly clears them.
    tick();
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h55;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk("preload_hi", hi, 32'h55);

    issue(OpMultu, 32'd5, 32'd7);
    repeat (8) tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    #3 reset = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 32'd0);

    run("multu_5x7", OpMultu, 32'd5, 32'd7);
    chk("multu_5x7_lo", lo, 32'd35);
    chk("multu_5x7_hi", hi, 32'd0);
    chk("multu_5x7_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    run("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

    run("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    run("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);

    run("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", hi, 32'd1);

    run("divu_100_7", OpDivu, 32'd100, 32'd7);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);

    run("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);
    chk("div_ovf_dbz", {31'd0, div_by_zero}, 32'd0);

    run("divu_zero", OpDivu, 32'h1234, 32'd0);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'h1234);
    chk("divu_zero_dbz", {31'd0, div_by_zero}, 32'd1);
    tick();
    chk("divu_zero_dbz_clear", {31'd0, div_by_zero}, 32'd0);

    run("div_zero_neg", OpDiv, 32'hFFFF_FFF9, 32'd0);
    chk("div_zero_neg_lo", lo, 32'hFFFF_FFFF);
    chk("div_zero_neg_hi", hi, 32'hFFFF_FFF9);
    chk("div_zero_neg_dbz", {31'd0, div_by_zero}, 32'd1);

    // Second start and an MTHI while busy must both be ignored.
    issue(OpMultu, 32'd6, 32'd7);
    repeat (4) tick();
    op = OpDivu; rs_data = 32'd9; rt_data = 32'd3;
    start = 1'b1; hi_wr = 1'b1; wr_data = 32'hAA;
    tick();
    start = 1'b0; hi_wr = 1'b0;
    chk("busy_hi_wr_ignored", hi, 32'hFFFF_FFF9);
    wait_done(6, n);
    chk("restart_latency", n, 32'd33);
    chk("restart_lo", lo, 32'd42);
    chk("restart_hi", hi, 32'd0);
    tick();
    chk("restart_not_queued", {31'd0, busy}, 32'd0);

    hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    hi_wr = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'd42);
    lo_wr = 1'b1; wr_data = 32'h0BAD_F00D;
    tick();
    lo_wr = 1'b0;
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

    // start and MTLO in the same idle cycle: start wins.
    op = OpMultu; rs_data = 32'd3; rt_data = 32'd4;
    start = 1'b1; lo_wr = 1'b1; wr_data = 32'h77;
    tick();
    start = 1'b0; lo_wr = 1'b0;
    chk("start_lo_wr_lost", lo, 32'h0BAD_F00D);
    chk("start_lo_wr_busy", {31'd0, busy}, 32'd1);
    wait_done(1, n);
    chk("mul3x4_latency", n, 32'd33);
    chk("mul3x4_hi", hi, 32'd0);
    chk("mul3x4_lo", lo, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
